// File: rtl/iot_pkg.sv
// Shared types and constants for the IoT batch arbiter slice.
//   state_t       : arbiter FSM states
//   fn_t          : function codes understood by the data-filter core
//   BYTES_PER_PKT : packet length in bytes
//   chw()         : index width for an n-entry selection
package iot_pkg;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        STREAM   = 2'd1,
        WAIT_PKT = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FN_RSVD  = 3'd0,
        FN_CODE1 = 3'd1,
        FN_CODE2 = 3'd2,
        FN_CODE3 = 3'd3,
        FN_CODE4 = 3'd4,
        FN_CODE5 = 3'd5,
        FN_CODE6 = 3'd6,
        FN_CODE7 = 3'd7
    } fn_t;

    localparam int BYTES_PER_PKT = 16;

    function automatic int chw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/iot_rr_pick.sv
// Combinational rotating-priority picker.
//   req_i      : request vector, one bit per channel
//   ptr_last_i : last owner; the search starts at ptr_last_i+1 and wraps
//   gnt_idx_o  : index of the first requester found (0 when none)
//   any_o      : at least one request is present
module iot_rr_pick
    import iot_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CW   = chw(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CW-1:0]   ptr_last_i,
    output logic [CW-1:0]   gnt_idx_o,
    output logic            any_o
);

    // Walk from lowest to highest priority so the last hit, i.e. the
    // channel closest after ptr_last_i, is the one that sticks.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            if (req_i[CW'((int'(ptr_last_i) + k) % N_CH)]) begin
                gnt_idx_o = CW'((int'(ptr_last_i) + k) % N_CH);
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iot_batch_arbiter.sv
// Round-robin batch sequencer in front of the IoT data-filter core.
// A channel owns the core for BATCH packets of 16 bytes, streamed as
// contiguous in_en bytes; core results are registered and tagged with the
// channel whose packet completed last. Stops after TOTAL_PKT packets.
//   clk, rst (sync, active-high)
//   cfg_fn_sel -> fn_sel   : function code, captured while rst is high
//   ch_pkt_rdy/ch_rd/ch_data : FWFT channel byte interface
//   in_en/iot_in/busy      : byte stream to the core
//   valid/iot_out -> res_* : tagged result capture
//   grant_ch, done         : status
module iot_batch_arbiter
    import iot_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int BATCH     = 8,
    parameter int TOTAL_PKT = 96
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            cfg_fn_sel,
    input  logic [N_CH-1:0]       ch_pkt_rdy,
    output logic [N_CH-1:0]       ch_rd,
    input  logic [N_CH*8-1:0]     ch_data,
    output logic                  in_en,
    output logic [7:0]            iot_in,
    output logic [2:0]            fn_sel,
    input  logic                  busy,
    input  logic                  valid,
    input  logic [127:0]          iot_out,
    output logic                  res_valid,
    output logic [127:0]          res_data,
    output logic [chw(N_CH)-1:0]  res_ch,
    output logic [chw(N_CH)-1:0]  grant_ch,
    output logic                  done
);

    localparam int              CW         = chw(N_CH);
    localparam int              BW         = $clog2(BATCH + 1);
    localparam logic [3:0]      LAST_BYTE  = 4'(BYTES_PER_PKT - 1);
    localparam logic [BW-1:0]   BATCH_LAST = BW'(BATCH - 1);
    localparam logic [6:0]      PKT_LAST   = 7'(TOTAL_PKT - 1);
    localparam logic [6:0]      PKT_MAX    = 7'(TOTAL_PKT);

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   tag_q, tag_d;
    logic [3:0]      byte_q, byte_d;
    logic [BW-1:0]   batch_q, batch_d;
    logic [6:0]      pkt_q, pkt_d;
    logic            in_en_q;
    logic [7:0]      iot_in_q;
    logic [2:0]      fn_sel_q;
    logic            res_valid_q;
    logic [127:0]    res_data_q;
    logic [CW-1:0]   res_ch_q;

    logic            issue;
    logic [7:0]      sel_byte;
    logic [CW-1:0]   pick_idx;
    logic            pick_any;

    iot_rr_pick #(.N_CH(N_CH), .CW(CW)) u_pick (
        .req_i      (ch_pkt_rdy),
        .ptr_last_i (ptr_q),
        .gnt_idx_o  (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_q == CW'(i)) sel_byte = ch_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        tag_d   = tag_q;
        byte_d  = byte_q;
        batch_d = batch_q;
        pkt_d   = pkt_q;
        issue   = 1'b0;
        ch_rd   = '0;

        case (state_q)
            ARB: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // busy is looked at before the byte goes out, so a byte
                // issued together with busy rising is still delivered.
                if (!busy) begin
                    issue  = 1'b1;
                    byte_d = byte_q + 4'd1;
                    if (byte_q == LAST_BYTE) begin
                        tag_d   = grant_q;
                        pkt_d   = (pkt_q == PKT_MAX) ? pkt_q : pkt_q + 7'd1;
                        batch_d = batch_q + BW'(1);
                        if (pkt_q == PKT_LAST) begin
                            state_d = DONE;
                        end else if (batch_q == BATCH_LAST) begin
                            batch_d = '0;
                            ptr_d   = grant_q;
                            state_d = ARB;
                        end else if (!ch_pkt_rdy[grant_q]) begin
                            state_d = WAIT_PKT;
                        end
                    end
                end
            end
            WAIT_PKT: begin
                if (ch_pkt_rdy[grant_q]) state_d = STREAM;
            end
            default: ;
        endcase

        if (issue) ch_rd[grant_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ARB;
            grant_q     <= '0;
            ptr_q       <= CW'(N_CH - 1);
            tag_q       <= '0;
            byte_q      <= '0;
            batch_q     <= '0;
            pkt_q       <= '0;
            in_en_q     <= 1'b0;
            iot_in_q    <= '0;
            fn_sel_q    <= cfg_fn_sel;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            tag_q       <= tag_d;
            byte_q      <= byte_d;
            batch_q     <= batch_d;
            pkt_q       <= pkt_d;
            in_en_q     <= issue;
            if (issue) iot_in_q <= sel_byte;
            res_valid_q <= valid;
            res_data_q  <= iot_out;
            res_ch_q    <= tag_q;
        end
    end

    assign in_en     = in_en_q;
    assign iot_in    = iot_in_q;
    assign fn_sel    = fn_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ch    = res_ch_q;
    assign grant_ch  = grant_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_iot_batch_arbiter.sv
// Directed bench for iot_batch_arbiter. A negedge monitor checks every
// byte against the channel byte read one cycle earlier and records the
// lengths/owners of contiguous in_en runs and the gaps between them.
module tb_iot_batch_arbiter;

    localparam int N_CH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   cfg_fn_sel;
    logic [3:0]   ch_pkt_rdy;
    logic [3:0]   ch_rd;
    logic [31:0]  ch_data;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic         busy;
    logic         valid;
    logic [127:0] iot_out;
    logic         res_valid;
    logic [127:0] res_data;
    logic [1:0]   res_ch;
    logic [1:0]   grant_ch;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    iot_batch_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_fn_sel (cfg_fn_sel),
        .ch_pkt_rdy (ch_pkt_rdy),
        .ch_rd      (ch_rd),
        .ch_data    (ch_data),
        .in_en      (in_en),
        .iot_in     (iot_in),
        .fn_sel     (fn_sel),
        .busy       (busy),
        .valid      (valid),
        .iot_out    (iot_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ch     (res_ch),
        .grant_ch   (grant_ch),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Channel sources: byte n of channel c is c*64+n (mod 256).
    int rd_idx [N_CH] = '{default: 0};
    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) if (ch_rd[c]) rd_idx[c] <= rd_idx[c] + 1;
    end
    always_comb begin
        for (int c = 0; c < N_CH; c++) ch_data[8*c +: 8] = 8'(c*64 + rd_idx[c]);
    end

    // Monitor state
    int         runs[$];
    int         gaps[$];
    int         run_owner[$];
    int         run_len, gap_len, beat_total, mon_err;
    logic [3:0] prev_rd;
    logic [7:0] prev_byte;
    int         prev_owner;

    always @(negedge clk) begin
        if (rst) begin
            runs.delete(); gaps.delete(); run_owner.delete();
            run_len = 0; gap_len = 0; beat_total = 0; mon_err = 0;
            prev_rd = '0; prev_byte = '0; prev_owner = 0;
        end else begin
            if (!$onehot0(ch_rd)) mon_err++;
            if (in_en !== (prev_rd != 4'd0)) mon_err++;
            if (in_en === 1'b1 && iot_in !== prev_byte) mon_err++;
            if (in_en === 1'b1) begin
                if (run_len == 0) begin
                    if (runs.size() > 0) gaps.push_back(gap_len);
                    run_owner.push_back(prev_owner);
                end
                run_len++; beat_total++; gap_len = 0;
            end else begin
                if (run_len != 0) begin
                    runs.push_back(run_len);
                    run_len = 0;
                end
                gap_len++;
            end
            prev_rd = ch_rd;
            for (int c = 0; c < N_CH; c++) begin
                if (ch_rd[c]) begin
                    prev_byte  = ch_data[8*c +: 8];
                    prev_owner = c;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [3:0] rdy);
        rst = 1'b1; ch_pkt_rdy = rdy; busy = 1'b0; valid = 1'b0; iot_out = '0;
        tick();
        check("rst_abort", {in_en, ch_rd, done}, 0);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int bad;

        // 1: reset state and idle with no requests
        cfg_fn_sel = 3'd3;
        do_reset(4'b0000);
        check("t1_fn_sel", fn_sel, 3);
        check("t1_grant", grant_ch, 0);
        check("t1_res_valid", res_valid, 0);
        cfg_fn_sel = 3'd5;
        bad = 0;
        repeat (20) begin
            tick();
            if (in_en !== 1'b0 || ch_rd !== 4'd0 || done !== 1'b0 || fn_sel !== 3'd3) bad++;
        end
        check("t1_idle", bad, 0);

        // 2: all channels ready, grant order 0,1,2,3,0 with 128-byte runs
        do_reset(4'b1111);
        n = 0;
        while (runs.size() < 5 && n < 2000) begin tick(); n++; end
        check("t2_timeout", runs.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_owner%0d", i), run_owner[i], i % 4);
            check($sformatf("t2_len%0d", i), runs[i], 128);
        end
        for (int i = 0; i < 4; i++) check($sformatf("t2_gap%0d", i), gaps[i], 1);
        check("t2_mon", mon_err, 0);

        // 3: only ch2, ch0 joins mid-batch without preempting
        do_reset(4'b0100);
        n = 0;
        while (beat_total < 40 && n < 200) begin tick(); n++; end
        check("t3_grant", grant_ch, 2);
        ch_pkt_rdy = 4'b0101;
        n = 0;
        while (runs.size() < 2 && n < 1000) begin tick(); n++; end
        check("t3_owner0", run_owner[0], 2);
        check("t3_len0", runs[0], 128);
        check("t3_owner1", run_owner[1], 0);
        check("t3_gap0", gaps[0], 1);
        check("t3_mon", mon_err, 0);

        // 4: busy for 5 cycles while byte 6 is pending
        do_reset(4'b0001);
        n = 0;
        while (beat_total != 5 && n < 200) begin tick(); n++; end
        busy = 1'b1;
        repeat (5) tick();
        busy = 1'b0;
        n = 0;
        while (runs.size() < 2 && n < 1000) begin tick(); n++; end
        check("t4_len0", runs[0], 6);
        check("t4_stall", gaps[0], 5);
        check("t4_len1", runs[1], 122);
        check("t4_mon", mon_err, 0);

        // 5: ch1 not ready after its 3rd packet for 10 cycles
        do_reset(4'b0010);
        n = 0;
        while (beat_total != 40 && n < 200) begin tick(); n++; end
        ch_pkt_rdy = 4'b0000;
        n = 0;
        while (beat_total != 48 && n < 200) begin tick(); n++; end
        repeat (10) tick();
        ch_pkt_rdy = 4'b0010;
        n = 0;
        while (runs.size() < 2 && n < 1000) begin tick(); n++; end
        check("t5_len0", runs[0], 48);
        check("t5_wait", gaps[0], 12);
        check("t5_len1", runs[1], 80);
        check("t5_owner1", run_owner[1], 1);
        check("t5_mon", mon_err, 0);

        // 6: tagged results around ch3's last byte, then run to done
        do_reset(4'b1111);
        n = 0;
        while (!(runs.size() == 3 && run_len == 127) && n < 1000) begin tick(); n++; end
        check("t6_owner3", run_owner[3], 3);
        valid = 1'b1; iot_out = {16{8'hA5}};
        tick();
        check("t6_res_valid", res_valid, 1);
        check("t6_res_data", res_data, {16{8'hA5}});
        check("t6_res_ch", res_ch, 3);
        iot_out = {16{8'h5A}};
        tick();
        valid = 1'b0; iot_out = '0;
        check("t6_res_data2", res_data, {16{8'h5A}});
        check("t6_res_ch_old", res_ch, 3);
        tick();
        check("t6_res_drop", res_valid, 0);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin tick(); n++; end
        check("t6_done", done, 1);
        bad = 0;
        repeat (20) begin
            tick();
            if (in_en !== 1'b0 || ch_rd !== 4'd0 || done !== 1'b1) bad++;
        end
        check("t6_quiet", bad, 0);
        check("t6_beats", beat_total, 96 * 16);
        check("t6_mon", mon_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
